// File: rtl/serial_sub4.sv
// serial_sub4 -- bit-serial N-bit subtractor, diff = a - b - bin (mod 2^N).
//
// One full-subtractor cell plus a registered borrow flop processes the
// operands LSB first, one bit per clock, behind a start/busy/done handshake.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset (priority over start)
//   start in   request, sampled only while idle
//   a     in   N-bit minuend, captured on the accepting edge
//   b     in   N-bit subtrahend, captured on the accepting edge
//   bin   in   borrow-in, captured on the accepting edge
//   busy  out  high while bits are being shifted through the cell
//   done  out  one-cycle pulse when diff/bout/ovf are updated
//   diff  out  N-bit difference, held until the next operation completes
//   bout  out  final borrow-out (a < b + bin, unsigned)
//   ovf   out  two's-complement overflow flag
//
// Build option: define SERIAL_SUB_OVF_EN to register the signed overflow
// flag; without it ovf is a constant 0 and no overflow logic exists.
module serial_sub4 #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  ra_q, ra_d;
  logic [N-1:0]  rb_q, rb_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          br_q, br_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;

  // Full-subtractor cell on the current LSBs.
  logic d_bit;
  logic br_nxt;
  logic last_bit;

  assign d_bit    = ra_q[0] ^ rb_q[0] ^ br_q;
  assign br_nxt   = (~ra_q[0] & rb_q[0]) | (~ra_q[0] & br_q) | (rb_q[0] & br_q);
  assign last_bit = (cnt_q == CW'(N - 1));

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          ra_d    = a;
          rb_d    = b;
          br_d    = bin;
          cnt_d   = '0;
          sh_d    = '0;
        end
      end
      S_SHIFT: begin
        br_d  = br_nxt;
        sh_d  = {d_bit, sh_q[N-1:1]};
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          // Outputs are published only here so they stay stable while
          // the next operation is still shifting.
          state_d = S_DONE;
          diff_d  = {d_bit, sh_q[N-1:1]};
          bout_d  = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
          // On the last bit ra[0]/rb[0] are the original operand MSBs.
          ovf_d   = (ra_q[0] ^ rb_q[0]) & (d_bit ^ ra_q[0]);
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Status flags are registered copies of the next state.
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub4.sv
// tb_serial_sub4 -- self-checking bench for serial_sub4 (N = 4).
// Expected results come from a plain-arithmetic model of a - b - bin.
module tb_serial_sub4;

  localparam int N = 4;
  localparam int MASK = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a, b;
  logic         bin;
  logic         busy, done, bout, ovf;
  logic [N-1:0] diff;

  int n_chk  = 0;
  int n_fail = 0;

  // Last completed result, used for hold checks.
  int last_diff = 0;
  int last_bout = 0;
  int last_ovf  = 0;

  serial_sub4 #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are observed 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: integer arithmetic on the operand values.
  function automatic void model(input int av, input int bv, input int cv,
                                output int ed, output int eb, output int eo);
    int sa, sb, sr;
    ed = (av - bv - cv) & MASK;
    eb = (av < bv + cv) ? 1 : 0;
    sa = (av >= (1 << (N - 1))) ? av - (1 << N) : av;
    sb = (bv >= (1 << (N - 1))) ? bv - (1 << N) : bv;
    sr = sa - sb - cv;
`ifdef SERIAL_SUB_OVF_EN
    eo = (sr > (1 << (N - 1)) - 1 || sr < -(1 << (N - 1))) ? 1 : 0;
`else
    eo = 0;
`endif
  endfunction

  // One full operation starting at the next edge. With noisy=1 a stray start
  // (a=1,b=1) is raised during busy and in the done cycle.
  task automatic run_op(input int av, input int bv, input int cv, input bit noisy,
                        input string tag);
    int ed, eb, eo;
    model(av, bv, cv, ed, eb, eo);
    a = N'(av); b = N'(bv); bin = cv[0]; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      // Operands must no longer matter once accepted.
      a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
      if (noisy && i == 1) begin start = 1'b1; a = 1; b = 1; bin = 0; end
      check({tag, ".busy"}, int'(busy), 1);
      check({tag, ".done_early"}, int'(done), 0);
      check({tag, ".diff_hold"}, int'(diff), last_diff);
      step();
      start = 1'b0;
    end
    check({tag, ".done"}, int'(done), 1);
    check({tag, ".busy_off"}, int'(busy), 0);
    check({tag, ".diff"}, int'(diff), ed);
    check({tag, ".bout"}, int'(bout), eb);
    check({tag, ".ovf"}, int'(ovf), eo);
    last_diff = ed; last_bout = eb; last_ovf = eo;
    if (noisy) begin start = 1'b1; a = 1; b = 1; bin = 0; end
    step();
    start = 1'b0;
    check({tag, ".done_fall"}, int'(done), 0);
    check({tag, ".busy_idle"}, int'(busy), 0);
    check({tag, ".diff_held"}, int'(diff), ed);
    check({tag, ".bout_held"}, int'(bout), eb);
    if (noisy) begin
      // A start taken in the done cycle would show busy here.
      for (int i = 0; i < N + 1; i++) begin
        step();
        check({tag, ".no_restart"}, int'(busy), 0);
        check({tag, ".no_done"}, int'(done), 0);
        check({tag, ".result_kept"}, int'(diff), ed);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;

    // Reset held two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
      step();
    end
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.diff", int'(diff), 0);
    check("rst.bout", int'(bout), 0);
    check("rst.ovf",  int'(ovf),  0);
    rst = 1'b0; start = 1'b0;
    step();

    // Directed cases.
    run_op(9, 4, 0, 1'b0, "basic");
    check("basic.const", last_diff, 5);
    run_op(3, 5, 0, 1'b0, "borrow");
    run_op(0, 0, 1, 1'b0, "bin_wrap");
    run_op(15, 15, 0, 1'b0, "equal");
    run_op(7, 15, 0, 1'b0, "ovf_pos");
    run_op(2, 1, 0, 1'b0, "ovf_none");

    // Stray starts during busy and done are ignored.
    run_op(12, 3, 1, 1'b1, "ignored_start");

    // Reset on the second shift cycle discards the operation.
    a = 9; b = 4; bin = 0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst.busy", int'(busy), 0);
    check("midrst.diff", int'(diff), 0);
    check("midrst.done", int'(done), 0);
    check("midrst.bout", int'(bout), 0);
    for (int i = 0; i < N + 2; i++) begin
      step();
      check("midrst.no_done", int'(done), 0);
    end
    last_diff = 0; last_bout = 0; last_ovf = 0;
    run_op(6, 2, 0, 1'b0, "after_rst");

    // Exhaustive sweep with back-to-back starts.
    for (int cv = 0; cv < 2; cv++)
      for (int av = 0; av < (1 << N); av++)
        for (int bv = 0; bv < (1 << N); bv++)
          run_op(av, bv, cv, 1'b0, "sweep");

    // Random operations, some with stray starts.
    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(MASK, 0)), int'($urandom_range(MASK, 0)),
             int'($urandom_range(1, 0)), 1'($urandom), "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sub4.md
# serial_sub4

Bit-serial N-bit subtractor (default 4) with borrow-in/borrow-out and a start/busy/done handshake. It is the subtract-direction companion of the team's combinational ripple-carry adder. It computes a − b − bin one bit per clock through a single full-subtractor cell and a registered borrow flip-flop, LSB first. On the DE1 board it sits behind switch/key glue, with results shown on LEDR.

## Interface
- N, 4: operand and result width, N ≥ 2.
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  N  minuend; sampled on the accepting edge.
- b  input  N  subtrahend; sampled on the accepting edge.
- bin  input  1  borrow-in; sampled on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; diff/bout/ovf are valid.
- diff  output  N  difference, held until the next accepted start.
- bout  output  1  final borrow-out; 1 when a < b + bin unsigned.
- ovf  output  1  signed (two's-complement) overflow flag, see Configuration.

## Operation
- States: IDLE, SHIFT, DONE; one-hot or binary encoding is acceptable.
- IDLE → SHIFT on start=1 at an edge.
  - Load shift registers ra←a, rb←b.
  - Load borrow flop br←bin.
  - Clear the bit counter cnt←0 (width ⌈log2 N⌉+1).
  - Clear the diff shift register.
- SHIFT, each edge processes one bit:
  - d = ra[0] ^ rb[0] ^ br.
  - br ← (~ra[0] & rb[0]) | (~ra[0] & br) | (rb[0] & br).
  - diff ← {d, diff[N-1:1]} (right shift, MSB-in).
  - ra, rb shift right by 1.
  - cnt ← cnt+1.
- SHIFT → DONE on the edge that processes bit N−1 (cnt = N−1).
  - On that same edge, bout ← the new br.
  - On that same edge, ovf is computed (when enabled).
- DONE → IDLE unconditionally on the next edge.
- start outside IDLE is ignored: no queuing, no restart. This includes start during DONE.
- Operands are not re-sampled after acceptance. Changes on a/b/bin during SHIFT have no effect.
- Arithmetic is modulo 2^N.
  - diff = (a − b − bin) mod 2^N.
  - bout = 1 iff a < b + bin, using unsigned N+1-bit comparison.
- rst=1 at any edge, including mid-SHIFT, forces:
  - state IDLE;
  - busy=0, done=0, diff=0, bout=0, ovf=0;
  - br, cnt, ra, rb cleared.
- The in-flight operation is discarded and no done pulse is issued.
- rst has priority over start.

## Timing
- Accepting edge = edge k (start=1 in IDLE).
- busy=1 for cycles following edges k … k+N−1 (N cycles); otherwise 0.
- done=1 for exactly the one cycle following edge k+N; busy=0 in that cycle.
- diff/bout/ovf update at edge k+N and stay stable until the next accepting edge.
- Latency from accepting edge to done: N+1 edges; N+2 including the done cycle.
- Minimum start-to-start spacing: N+2 cycles. Earliest re-accept is at edge k+N+1+1, in IDLE.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: SERIAL_SUB_OVF_EN.
- Defined: ovf is registered at edge k+N as (a_msb ^ b_msb) & (d_msb ^ a_msb).
  - a_msb and b_msb are the original operand MSBs, i.e. ra[0] and rb[0] on the final SHIFT edge.
  - d_msb is the final difference bit.
  - ovf is held like diff.
- Not defined: ovf is tied to constant 0 and no overflow logic is synthesized. The port remains present so the interface is identical.

## Test plan
- Reset: hold rst 2 cycles with random inputs → busy=0, done=0, diff=0, bout=0, ovf=0.
- Basic subtract: a=9, b=4, bin=0, start pulse → busy high 4 cycles, then done pulse with diff=5, bout=0. done falls the next cycle.
- Borrow chain, wrap, and exhaustive check:
  - a=3, b=5, bin=0 → diff=14, bout=1.
  - a=0, b=0, bin=1 → diff=15, bout=1.
  - a=15, b=15, bin=0 → diff=0, bout=0.
  - Exhaustive loop over all 512 (a, b, bin) combinations against the model, using back-to-back starts issued as soon as each re-accept is allowed.
- Signed overflow:
  - a=7, b=15 (+7 − (−1)) → diff=8, ovf=1 with SERIAL_SUB_OVF_EN, ovf=0 without.
  - a=2, b=1 → ovf=0 in both builds.
- Ignored start: issue a second start with a=1, b=1 during busy and in the done cycle → the first result is unaffected, only one done pulse occurs, and no second operation begins.
- Reset mid-op: assert rst on the 2nd SHIFT cycle of a=9, b=4 → the next cycle shows busy=0, diff=0, and no done pulse. A following start with a=6, b=2 completes normally with diff=4.
